// File: rtl/poly_series_pipe_if.sv
// ----------------------------------------------------------------------------
// poly_series_pipe_if
// Bundles the operand handshake, the coefficient write port and the result
// strobe of poly_series_pipe.
//   master : producer/consumer side (drives operands and coefficient writes,
//            observes in_ready and the result strobe)
//   slave  : the evaluator itself
// Signals
//   coef_we / coef_addr / coef_data : coefficient table write
//   in_valid / in_ready / in_x / in_n : operand handshake
//   out_valid / out_result / out_ovf  : one-cycle result strobe
// ----------------------------------------------------------------------------
interface poly_series_pipe_if #(
    parameter int W         = 8,
    parameter int MAX_TERMS = 8
);
    localparam int NW = $clog2(MAX_TERMS + 1);
    localparam int AW = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;

    logic          coef_we;
    logic [AW-1:0] coef_addr;
    logic [W-1:0]  coef_data;

    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_x;
    logic [NW-1:0] in_n;

    logic          out_valid;
    logic [W-1:0]  out_result;
    logic          out_ovf;

    modport master (
        output coef_we, coef_addr, coef_data,
        output in_valid, in_x, in_n,
        input  in_ready,
        input  out_valid, out_result, out_ovf
    );

    modport slave (
        input  coef_we, coef_addr, coef_data,
        input  in_valid, in_x, in_n,
        output in_ready,
        output out_valid, out_result, out_ovf
    );
endinterface

// File: rtl/poly_series_pipe.sv
// ----------------------------------------------------------------------------
// poly_series_pipe
// Pipelined, recirculating evaluator of y = sum_{k=1..n} c[k-1] * x^k in
// signed Q(W-FRAC).FRAC with saturating arithmetic. A ring of STAGES slots
// each computes one term per pass; operations needing more than STAGES terms
// go round the ring again, taking priority over new operands.
// Ports
//   clk     : clock
//   rst     : synchronous active-high reset (clears pipeline, flags, table)
//   flush   : synchronous pipeline clear, coefficient table kept
//   bus     : slave side of poly_series_pipe_if (operands, coefficients,
//             result strobe)
//   ov_flag : sticky OR of out_ovf, cleared by rst or flush
//   busy    : any pipeline slot valid
// ----------------------------------------------------------------------------
module poly_series_pipe #(
    parameter int W         = 8,
    parameter int FRAC      = 6,
    parameter int STAGES    = 4,
    parameter int MAX_TERMS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    poly_series_pipe_if.slave     bus,
    output logic                  ov_flag,
    output logic                  busy
);
    localparam int NW = $clog2(MAX_TERMS + 1);
    localparam int AW = (MAX_TERMS > 1) ? $clog2(MAX_TERMS) : 1;
    localparam int L  = STAGES - 1;

    localparam logic [NW-1:0]          N_MAX = NW'(MAX_TERMS);
    localparam logic [AW:0]            A_LIM = (AW + 1)'(MAX_TERMS);
    localparam logic signed [W-1:0]    ONE   = W'(1 << FRAC);
    localparam logic signed [W-1:0]    S_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0]    S_MIN = {1'b1, {(W-1){1'b0}}};
    localparam logic signed [2*W-1:0]  P_MAX = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [2*W-1:0]  P_MIN = {{(W+1){1'b1}}, {(W-1){1'b0}}};

    // Fixed-point multiply: full product, floor shift, clamp. MSB of the
    // return value flags saturation.
    function automatic logic [W:0] f_mul_sat(input logic signed [W-1:0] a,
                                             input logic signed [W-1:0] b);
        logic signed [2*W-1:0] p;
        logic [W:0]            r;
        p = a * b;
        p = p >>> FRAC;
        if (p > P_MAX)      r = {1'b1, S_MAX};
        else if (p < P_MIN) r = {1'b1, S_MIN};
        else                r = {1'b0, p[W-1:0]};
        return r;
    endfunction

    // Saturating add; MSB of the return value flags saturation.
    function automatic logic [W:0] f_add_sat(input logic signed [W-1:0] a,
                                             input logic signed [W-1:0] b);
        logic [W:0] s;
        logic [W:0] r;
        s = {a[W-1], a} + {b[W-1], b};
        if (s[W] != s[W-1]) r = {1'b1, (s[W] ? S_MIN : S_MAX)};
        else                r = {1'b0, s[W-1:0]};
        return r;
    endfunction

    // Slot registers: r_*[i] holds the output of stage i
    logic                 r_vld [STAGES];
    logic signed [W-1:0]  r_x   [STAGES];
    logic signed [W-1:0]  r_xp  [STAGES];
    logic signed [W-1:0]  r_acc [STAGES];
    logic [NW-1:0]        r_k   [STAGES];
    logic [NW-1:0]        r_n   [STAGES];
    logic                 r_ovf [STAGES];

    logic signed [W-1:0]  r_coef [MAX_TERMS];

    logic                 r_out_valid;
    logic [W-1:0]         r_out_result;
    logic                 r_out_ovf;
    logic                 r_ov_flag;

    // Stage inputs / outputs
    logic                 w_i_vld [STAGES];
    logic signed [W-1:0]  w_i_x   [STAGES];
    logic signed [W-1:0]  w_i_xp  [STAGES];
    logic signed [W-1:0]  w_i_acc [STAGES];
    logic [NW-1:0]        w_i_k   [STAGES];
    logic [NW-1:0]        w_i_n   [STAGES];
    logic                 w_i_ovf [STAGES];

    logic                 w_o_vld [STAGES];
    logic signed [W-1:0]  w_o_x   [STAGES];
    logic signed [W-1:0]  w_o_xp  [STAGES];
    logic signed [W-1:0]  w_o_acc [STAGES];
    logic [NW-1:0]        w_o_k   [STAGES];
    logic [NW-1:0]        w_o_n   [STAGES];
    logic                 w_o_ovf [STAGES];

    logic                 w_recirc;
    logic                 w_retire;
    logic                 w_accept;
    logic [NW-1:0]        w_n_clamped;

    // The last slot either goes round again or retires; a recirculating op
    // owns stage 0 for that cycle, which is the only reason to stall input.
    assign w_recirc    = r_vld[L] && (r_k[L] < r_n[L]);
    assign w_retire    = r_vld[L] && !(r_k[L] < r_n[L]);
    assign bus.in_ready = !w_recirc;
    assign w_accept    = bus.in_valid && !w_recirc;
    assign w_n_clamped = (bus.in_n > N_MAX) ? N_MAX : bus.in_n;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic       w_act;
            logic [W:0] w_m1;
            logic [W:0] w_m2;
            logic [W:0] w_ad;

            if (gi == 0) begin : g_entry
                assign w_i_vld[gi] = w_recirc ? 1'b1     : w_accept;
                assign w_i_x[gi]   = w_recirc ? r_x[L]   : bus.in_x;
                assign w_i_xp[gi]  = w_recirc ? r_xp[L]  : ONE;
                assign w_i_acc[gi] = w_recirc ? r_acc[L] : '0;
                assign w_i_k[gi]   = w_recirc ? r_k[L]   : '0;
                assign w_i_n[gi]   = w_recirc ? r_n[L]   : w_n_clamped;
                assign w_i_ovf[gi] = w_recirc ? r_ovf[L] : 1'b0;
            end else begin : g_chain
                assign w_i_vld[gi] = r_vld[gi-1];
                assign w_i_x[gi]   = r_x[gi-1];
                assign w_i_xp[gi]  = r_xp[gi-1];
                assign w_i_acc[gi] = r_acc[gi-1];
                assign w_i_k[gi]   = r_k[gi-1];
                assign w_i_n[gi]   = r_n[gi-1];
                assign w_i_ovf[gi] = r_ovf[gi-1];
            end

            // Slots that already have all their terms pass through untouched;
            // the coefficient index is only meaningful while k < n.
            assign w_act = w_i_k[gi] < w_i_n[gi];
            assign w_m1  = f_mul_sat(w_i_xp[gi], w_i_x[gi]);
            assign w_m2  = f_mul_sat(w_m1[W-1:0], r_coef[w_i_k[gi][AW-1:0]]);
            assign w_ad  = f_add_sat(w_i_acc[gi], w_m2[W-1:0]);

            assign w_o_vld[gi] = w_i_vld[gi];
            assign w_o_x[gi]   = w_i_x[gi];
            assign w_o_n[gi]   = w_i_n[gi];
            assign w_o_xp[gi]  = w_act ? w_m1[W-1:0] : w_i_xp[gi];
            assign w_o_acc[gi] = w_act ? w_ad[W-1:0] : w_i_acc[gi];
            assign w_o_k[gi]   = w_act ? (w_i_k[gi] + NW'(1)) : w_i_k[gi];
            assign w_o_ovf[gi] = w_i_ovf[gi] | (w_act & (w_m1[W] | w_m2[W] | w_ad[W]));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                r_vld[i] <= 1'b0;
                r_x[i]   <= '0;
                r_xp[i]  <= '0;
                r_acc[i] <= '0;
                r_k[i]   <= '0;
                r_n[i]   <= '0;
                r_ovf[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                // flush drops everything, including an operand accepted now
                r_vld[i] <= flush ? 1'b0 : w_o_vld[i];
                r_x[i]   <= w_o_x[i];
                r_xp[i]  <= w_o_xp[i];
                r_acc[i] <= w_o_acc[i];
                r_k[i]   <= w_o_k[i];
                r_n[i]   <= w_o_n[i];
                r_ovf[i] <= w_o_ovf[i];
            end
        end
    end

    // Coefficients may only change while nothing is in flight, so every
    // operation sees one consistent table.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MAX_TERMS; i++) r_coef[i] <= '0;
        end else if (bus.coef_we && !busy && ({1'b0, bus.coef_addr} < A_LIM)) begin
            r_coef[bus.coef_addr] <= bus.coef_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_ovf    <= 1'b0;
            r_ov_flag    <= 1'b0;
        end else begin
            r_out_valid <= w_retire && !flush;
            if (w_retire && !flush) begin
                r_out_result <= r_acc[L];
                r_out_ovf    <= r_ovf[L];
            end
            if (flush)                     r_ov_flag <= 1'b0;
            else if (w_retire && r_ovf[L]) r_ov_flag <= 1'b1;
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int i = 0; i < STAGES; i++) busy = busy | r_vld[i];
    end

    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_ovf    = r_out_ovf;
    assign ov_flag        = r_ov_flag;
endmodule

// File: tb/tb_poly_series_pipe.sv
module tb_poly_series_pipe;
    localparam int W = 8, FRAC = 6, STAGES = 4, MAX_TERMS = 8, NW = 4, AW = 3;

    logic clk = 1'b0;
    logic rst, flush, ov_flag, busy;

    poly_series_pipe_if #(.W(W), .MAX_TERMS(MAX_TERMS)) bus ();

    poly_series_pipe #(.W(W), .FRAC(FRAC), .STAGES(STAGES), .MAX_TERMS(MAX_TERMS)) dut (
        .clk(clk), .rst(rst), .flush(flush), .bus(bus), .ov_flag(ov_flag), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int    res;
        bit    ovf;
        int    at;
        string tag;
    } exp_t;
    exp_t sb[$];
    int   coef_m[MAX_TERMS];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp8(input int v);
        if (v > 127)  return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    function automatic int nclamp(input int n);
        return (n > MAX_TERMS) ? MAX_TERMS : n;
    endfunction

    function automatic int latency(input int n);
        int p;
        p = (nclamp(n) + STAGES - 1) / STAGES;
        if (p < 1) p = 1;
        return STAGES * p;
    endfunction

    // Reference: y = sum c[k-1]*x^k with floor-shift multiply and clamping
    function automatic void model(input int x, input int n, output int res, output bit ovf);
        int xp, acc, t, p;
        xp = 64; acc = 0; ovf = 1'b0;
        for (int k = 0; k < nclamp(n); k++) begin
            t = (xp * x) >>> FRAC;          if (clamp8(t) != t) ovf = 1'b1; xp = clamp8(t);
            t = (xp * coef_m[k]) >>> FRAC;  if (clamp8(t) != t) ovf = 1'b1; p = clamp8(t);
            t = acc + p;                    if (clamp8(t) != t) ovf = 1'b1; acc = clamp8(t);
        end
        res = acc & 255;
    endfunction

    // Offer an operand at a negedge, wait for acceptance; exp_res < 0 means
    // the expected value comes from the reference model.
    task automatic send(input string tag, input int x, input int n, input bit push,
                        input int exp_res, input bit exp_ovf, output int acc_at);
        int w;
        int r;
        bit o;
        logic [31:0] xv;
        xv = x;
        bus.in_valid = 1'b1;
        bus.in_x     = xv[W-1:0];
        bus.in_n     = NW'(n);
        w = 0;
        while (!bus.in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) chk({tag, "_in_ready"}, {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);
        acc_at = cyc;
        bus.in_valid = 1'b0;
        if (push) begin
            if (exp_res < 0) model(x, n, r, o);
            else begin r = exp_res; o = exp_ovf; end
            sb.push_back('{res: r, ovf: o, at: acc_at + latency(n), tag: tag});
            $display("send %s x=%0d n=%0d acc_cyc=%0d exp=0x%02h ovf=%0b at=%0d",
                     tag, x, n, acc_at, r, o, acc_at + latency(n));
        end else begin
            $display("send %s x=%0d n=%0d acc_cyc=%0d (no result expected)", tag, x, n, acc_at);
        end
    endtask

    task automatic write_coef(input int addr, input int data, input bit takes_effect);
        logic [31:0] dv;
        dv = data;
        bus.coef_we   = 1'b1;
        bus.coef_addr = AW'(addr);
        bus.coef_data = dv[W-1:0];
        @(negedge clk);
        bus.coef_we = 1'b0;
        if (takes_effect) coef_m[addr] = clamp8(data);
    endtask

    task automatic wait_idle(input string tag);
        int w;
        w = 0;
        while ((sb.size() != 0 || busy) && w < 300) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_drained"}, sb.size(), 32'd0);
        chk({tag, "_idle"}, {31'b0, busy}, 32'd0);
    endtask

    // Scoreboard: every expected result is tied to one cycle; anything else
    // on out_valid is unexpected.
    always @(negedge clk) begin
        bit hit;
        hit = 1'b0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == cyc) begin
                hit = 1'b1;
                chk({sb[i].tag, "_valid"},  {31'b0, bus.out_valid}, 32'd1);
                chk({sb[i].tag, "_result"}, {24'b0, bus.out_result}, sb[i].res);
                chk({sb[i].tag, "_ovf"},    {31'b0, bus.out_ovf}, {31'b0, sb[i].ovf});
                if (sb[i].ovf) chk({sb[i].tag, "_ov_flag"}, {31'b0, ov_flag}, 32'd1);
                $display("result %s cyc=%0d y=0x%02h ovf=%0b", sb[i].tag, cyc,
                         bus.out_result, bus.out_ovf);
                sb.delete(i);
            end
        end
        if (!hit && bus.out_valid === 1'b1)
            chk("unexpected_out_valid", {31'b0, bus.out_valid}, 32'd0);
    end

    initial begin
        int a, a0, r;
        int cvals[MAX_TERMS] = '{64, -32, 32, 16, -64, 127, 8, -128};
        int xs[4] = '{32, -32, 16, 48};

        rst = 1'b1; flush = 1'b0;
        bus.in_valid = 1'b0; bus.in_x = '0; bus.in_n = '0;
        bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
        for (int i = 0; i < MAX_TERMS; i++) coef_m[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_out_valid",  {31'b0, bus.out_valid}, 32'd0);
        chk("rst_out_result", {24'b0, bus.out_result}, 32'd0);
        chk("rst_out_ovf",    {31'b0, bus.out_ovf}, 32'd0);
        chk("rst_ov_flag",    {31'b0, ov_flag}, 32'd0);
        chk("rst_busy",       {31'b0, busy}, 32'd0);
        chk("rst_in_ready",   {31'b0, bus.in_ready}, 32'd1);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < MAX_TERMS; i++) write_coef(i, 64, 1'b1);

        // 0.5 + 0.25
        send("t1", 32, 2, 1'b1, 'h30, 1'b0, a);
        wait_idle("t1");

        // six terms, one recirculation stall
        send("t2", 32, 6, 1'b1, 'h3F, 1'b0, a);
        @(negedge clk); @(negedge clk);
        chk("t2_ready_before", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);
        chk("t2_ready_recirc", {31'b0, bus.in_ready}, 32'd0);
        @(negedge clk);
        chk("t2_ready_after",  {31'b0, bus.in_ready}, 32'd1);
        wait_idle("t2");

        // 1.5^2 saturates
        send("t3", 96, 4, 1'b1, 'h7F, 1'b1, a);
        wait_idle("t3");
        chk("t3_ov_flag", {31'b0, ov_flag}, 32'd1);
        send("t3b", 32, 1, 1'b1, -1, 1'b0, a);
        wait_idle("t3b");
        chk("t3b_ov_flag_sticky", {31'b0, ov_flag}, 32'd1);

        // back-to-back n=3, then n=5
        send("t4_0", xs[0], 3, 1'b1, -1, 1'b0, a0);
        for (int i = 1; i < 4; i++) begin
            send($sformatf("t4_%0d", i), xs[i], 3, 1'b1, -1, 1'b0, a);
            chk($sformatf("t4_%0d_b2b", i), a, a0 + i);
        end
        send("t4_n5", 24, 5, 1'b1, -1, 1'b0, a);
        chk("t4_n5_b2b", a, a0 + 4);
        repeat (3) @(negedge clk);
        chk("t4_ready_low", {31'b0, bus.in_ready}, 32'd0);
        wait_idle("t4");

        // distinct signed coefficients, random operands, mixed pass counts
        for (int i = 0; i < MAX_TERMS; i++) write_coef(i, cvals[i], 1'b1);
        for (int i = 0; i < 10; i++) begin
            r = int'($urandom_range(0, 255));
            if (r > 127) r = r - 256;
            send($sformatf("t4r_%0d", i), r, int'($urandom_range(0, 9)), 1'b1, -1, 1'b0, a);
        end
        wait_idle("t4r");

        // flush with in-flight op, dropped coefficient write, op on flush cycle
        send("t5_flushed", 32, 7, 1'b0, -1, 1'b0, a);
        chk("t5_busy", {31'b0, busy}, 32'd1);
        write_coef(0, 'h11, 1'b0);
        flush = 1'b1;
        send("t5_on_flush", 16, 2, 1'b0, -1, 1'b0, a);
        flush = 1'b0;
        chk("t5_busy_after_flush",  {31'b0, busy}, 32'd0);
        chk("t5_ready_after_flush", {31'b0, bus.in_ready}, 32'd1);
        chk("t5_ov_flag_cleared",   {31'b0, ov_flag}, 32'd0);
        repeat (12) @(negedge clk);
        send("t5_readback", 64, 1, 1'b1, 'h40, 1'b0, a);
        wait_idle("t5");

        // n=0, n beyond the table
        send("t6_n0", 40, 0, 1'b1, 'h00, 1'b0, a);
        send("t6_n9", 16, 9, 1'b1, -1, 1'b0, a);
        send("t6_n15", -20, 15, 1'b1, -1, 1'b0, a);
        wait_idle("t6");

        // reset mid-operation clears the table too
        send("t6_rst_flight", 32, 8, 1'b0, -1, 1'b0, a);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < MAX_TERMS; i++) coef_m[i] = 0;
        chk("t6_rst_busy",    {31'b0, busy}, 32'd0);
        chk("t6_rst_ov_flag", {31'b0, ov_flag}, 32'd0);
        repeat (10) @(negedge clk);
        send("t6_after_rst_a", 32, 3, 1'b1, 'h00, 1'b0, a);
        send("t6_after_rst_b", -100, 5, 1'b1, -1, 1'b0, a);
        wait_idle("t6_rst");

        chk("final_scoreboard_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
